// File: rtl/mem_line_initiator.sv
// mem_line_initiator: cache-side initiator for the external memory protocol.
// Takes one cache line read or write, issues a tagged request, then either
// streams the write beats or assembles the tagged read beats into a line.
module mem_line_initiator #(
  parameter int unsigned MEM_DATA_BITS = 128,
  parameter int unsigned MEM_ADDR_BITS = 28,
  parameter int unsigned MEM_TAG_BITS  = 5,
  parameter int unsigned BEATS         = 4,
  parameter int unsigned TIMEOUT       = 1024
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   req_valid,
  output logic                                   req_ready,
  input  logic                                   req_rw,
  input  logic [MEM_ADDR_BITS-1:0]               req_addr,
  input  logic [BEATS*MEM_DATA_BITS-1:0]         req_wdata,
  input  logic [BEATS*MEM_DATA_BITS/8-1:0]       req_wmask,
  output logic                                   resp_valid,
  output logic                                   resp_rw,
  output logic [BEATS*MEM_DATA_BITS-1:0]         resp_data,
  output logic                                   mem_req_valid,
  output logic                                   mem_req_rw,
  output logic [MEM_ADDR_BITS-1:0]               mem_req_addr,
  output logic [MEM_TAG_BITS-1:0]                mem_req_tag,
  input  logic                                   mem_req_ready,
  output logic                                   mem_req_data_valid,
  output logic [MEM_DATA_BITS-1:0]               mem_req_data_bits,
  output logic [MEM_DATA_BITS/8-1:0]             mem_req_data_mask,
  input  logic                                   mem_req_data_ready,
  input  logic                                   mem_resp_valid,
  input  logic [MEM_TAG_BITS-1:0]                mem_resp_tag,
  input  logic [MEM_DATA_BITS-1:0]               mem_resp_data,
  output logic                                   err_tag,
  output logic                                   err_timeout
);

  localparam int unsigned MASK_BITS = MEM_DATA_BITS / 8;
  localparam int unsigned BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned WAIT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WDATA = 3'd2,
    S_RRESP = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                                  r_state;
  state_t                                  w_next;
  logic                                    r_rw;
  logic [MEM_ADDR_BITS-1:0]                r_addr;
  logic [BEATS-1:0][MEM_DATA_BITS-1:0]     r_wdata;
  logic [BEATS-1:0][MASK_BITS-1:0]         r_wmask;
  logic [BEATS-1:0][MEM_DATA_BITS-1:0]     r_rdata;
  logic [MEM_TAG_BITS-1:0]                 r_tag_ctr;
  logic [MEM_TAG_BITS-1:0]                 r_cur_tag;
  logic [BEAT_W-1:0]                       r_beat_cnt;
  logic [WAIT_W-1:0]                       r_wait_cnt;
  logic                                    r_err_tag;
  logic                                    r_err_timeout;

  logic                                    w_accept;
  logic                                    w_beat_last;
  logic                                    w_resp_hit;
  logic                                    w_timeout;

  // Shared qualifiers for the FSM and datapath
  always_comb begin
    w_accept    = req_valid && (r_state == S_IDLE);
    w_beat_last = (r_beat_cnt == BEAT_W'(BEATS - 1));
    w_resp_hit  = mem_resp_valid && (r_state == S_RRESP) && (mem_resp_tag == r_cur_tag);
    // A final matching beat on the timeout cycle still completes the line cleanly
    w_timeout   = (TIMEOUT != 0) && (r_state == S_RRESP) &&
                  (r_wait_cnt == WAIT_W'(TIMEOUT)) && !(w_resp_hit && w_beat_last);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    w_next             = r_state;
    req_ready          = 1'b0;
    mem_req_valid      = 1'b0;
    mem_req_data_valid = 1'b0;
    mem_req_data_mask  = '0;
    resp_valid         = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = S_REQ;
      end
      S_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) w_next = r_rw ? S_WDATA : S_RRESP;
      end
      S_WDATA: begin
        mem_req_data_valid = 1'b1;
        mem_req_data_mask  = r_wmask[r_beat_cnt];
        if (mem_req_data_ready && w_beat_last) w_next = S_DONE;
      end
      S_RRESP: begin
        if ((w_resp_hit && w_beat_last) || w_timeout) w_next = S_DONE;
      end
      S_DONE: begin
        resp_valid = 1'b1;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch, tag/beat/wait counters, read line assembly, sticky errors
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rw          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wmask       <= '0;
      r_rdata       <= '0;
      r_tag_ctr     <= '0;
      r_cur_tag     <= '0;
      r_beat_cnt    <= '0;
      r_wait_cnt    <= '0;
      r_err_tag     <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rw      <= req_rw;
        r_addr    <= req_addr;
        r_wdata   <= req_wdata;
        r_wmask   <= req_wmask;
        r_rdata   <= '0;
        r_cur_tag <= r_tag_ctr;
      end
      if ((r_state == S_REQ) && mem_req_ready) begin
        r_tag_ctr  <= r_tag_ctr + MEM_TAG_BITS'(1);
        r_beat_cnt <= '0;
        r_wait_cnt <= '0;
      end
      if ((r_state == S_WDATA) && mem_req_data_ready) begin
        r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
      end
      if (r_state == S_RRESP) begin
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end
      if (w_resp_hit) begin
        r_rdata[r_beat_cnt] <= mem_resp_data;
        r_beat_cnt          <= r_beat_cnt + BEAT_W'(1);
      end
      if (mem_resp_valid && !w_resp_hit) r_err_tag <= 1'b1;
      if (w_timeout) r_err_timeout <= 1'b1;
    end
  end

  // Registered request/response fields
  always_comb begin
    mem_req_rw        = r_rw;
    mem_req_addr      = r_addr;
    mem_req_tag       = r_cur_tag;
    mem_req_data_bits = r_wdata[r_beat_cnt];
    resp_rw           = r_rw;
    resp_data         = r_rdata;
    err_tag           = r_err_tag;
    err_timeout       = r_err_timeout;
  end

endmodule
